// File: rtl/led_breather_pkg.sv
// -----------------------------------------------------------------------------
// led_breather_pkg
// Shared types and helpers for the LED breathing driver.
//   phase_t  : breathing sequence phase, encoded exactly as seen on the phase
//              output (0 UP, 1 HI_HOLD, 2 DOWN, 3 LO_HOLD).
//   stepDiv  : number of sysClk cycles per brightness step.
// -----------------------------------------------------------------------------
package led_breather_pkg;

    typedef enum logic [1:0] {
        UP      = 2'd0,
        HI_HOLD = 2'd1,
        DOWN    = 2'd2,
        LO_HOLD = 2'd3
    } phase_t;

    // Clock cycles per brightness step; callers keep the result >= 2 so the
    // prescaler always has at least one non-tick cycle.
    function automatic int stepDiv(input int clkHz, input int stepHz);
        return clkHz / stepHz;
    endfunction

endpackage

// File: rtl/led_breather_pwm_gen.sv
// -----------------------------------------------------------------------------
// pwm_gen
// Free-running PWM counter plus compare stage for the LED pin.
// Ports:
//   sysClk  in   1         clock, rising edge
//   rstN    in   1         asynchronous active-low reset
//   en      in   1         LED enable; 0 forces the registered output low
//   duty    in   PWM_BITS  on-time in counter steps out of 2**PWM_BITS
//   led     out  1         registered PWM output
// The counter keeps running while en is low, so the PWM phase is tied only to
// the time since reset release.
// -----------------------------------------------------------------------------
module pwm_gen
    import led_breather_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                sysClk,
    input  logic                rstN,
    input  logic                en,
    input  logic [PWM_BITS-1:0] duty,
    output logic                led
);

    logic [PWM_BITS-1:0] r_pwmCnt;
    logic                r_led;

    // Strict less-than: duty 0 never lights, full-scale duty stays dark for
    // one counter step per period.
    always_ff @(posedge sysClk or negedge rstN) begin
        if (!rstN) begin
            r_pwmCnt <= '0;
            r_led    <= 1'b0;
        end else begin
            r_pwmCnt <= r_pwmCnt + 1'b1;
            r_led    <= en & (r_pwmCnt < duty);
        end
    end

    assign led = r_led;

endmodule

// File: rtl/led_breather.sv
// -----------------------------------------------------------------------------
// led_breather
// LED "breathing" driver: triangle brightness ramp (fade up, hold, fade down,
// hold) rendered as PWM on one LED pin.
// Ports:
//   sysClk     in   1         system clock, rising edge
//   rstN       in   1         asynchronous active-low reset
//   en         in   1         run enable; 0 freezes the sequence, blanks LED
//   led        out  1         registered PWM LED drive
//   level      out  PWM_BITS  current brightness
//   phase      out  2         0 UP, 1 HI_HOLD, 2 DOWN, 3 LO_HOLD
//   cycleDone  out  1         one-clock pulse when DOWN -> LO_HOLD is taken
// Build option:
//   LED_BREATHER_GAMMA_EN  defined   : duty = (level*level) >> PWM_BITS,
//                                      registered (one cycle of duty lag)
//                          undefined : duty = level
// -----------------------------------------------------------------------------
module led_breather
    import led_breather_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int STEP_HZ    = 1_000,
    parameter int PWM_BITS   = 8,
    parameter int HOLD_STEPS = 64
) (
    input  logic                sysClk,
    input  logic                rstN,
    input  logic                en,
    output logic                led,
    output logic [PWM_BITS-1:0] level,
    output logic [1:0]          phase,
    output logic                cycleDone
);

    localparam int STEP_DIV = stepDiv(CLK_HZ, STEP_HZ);
    localparam int PS_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HC_W     = $clog2(HOLD_STEPS + 1);

    localparam logic [PS_W-1:0]     PS_LAST = PS_W'(STEP_DIV - 1);
    localparam logic [HC_W-1:0]     HC_LAST = HC_W'(HOLD_STEPS);
    localparam logic [PWM_BITS-1:0] LMAX    = '1;

    logic [PS_W-1:0]     r_presc;
    logic [HC_W-1:0]     r_holdCnt;
    logic [PWM_BITS-1:0] r_level;
    phase_t              r_phase;
    logic                r_cycleDone;

    logic                w_tick;
    logic [PWM_BITS-1:0] w_levelInc;
    logic [PWM_BITS-1:0] w_levelDec;
    logic [HC_W-1:0]     w_holdInc;
    logic [PWM_BITS-1:0] w_duty;

    assign w_tick     = en & (r_presc == PS_LAST);
    assign w_levelInc = r_level + 1'b1;
    assign w_levelDec = r_level - 1'b1;
    assign w_holdInc  = r_holdCnt + 1'b1;

    // Step prescaler. Clearing it whenever en is low means a resumed sequence
    // always waits a full STEP_DIV enabled clocks for its next step, and a
    // tick can never coincide with en low.
    always_ff @(posedge sysClk or negedge rstN) begin
        if (!rstN) begin
            r_presc <= '0;
        end else if (!en || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Breathing sequencer. Phase changes are decided on the post-step value,
    // so level saturates at LMAX/0 without explicit clamping. Since nothing
    // moves without a tick, dropping en freezes level, phase and holdCnt.
    always_ff @(posedge sysClk or negedge rstN) begin
        if (!rstN) begin
            r_phase     <= UP;
            r_level     <= '0;
            r_holdCnt   <= '0;
            r_cycleDone <= 1'b0;
        end else begin
            r_cycleDone <= 1'b0;
            if (w_tick) begin
                case (r_phase)
                    UP: begin
                        r_level <= w_levelInc;
                        if (w_levelInc == LMAX) begin
                            r_phase   <= HI_HOLD;
                            r_holdCnt <= '0;
                        end
                    end
                    HI_HOLD: begin
                        r_holdCnt <= w_holdInc;
                        if (w_holdInc == HC_LAST) begin
                            r_phase <= DOWN;
                        end
                    end
                    DOWN: begin
                        r_level <= w_levelDec;
                        if (w_levelDec == '0) begin
                            r_phase     <= LO_HOLD;
                            r_holdCnt   <= '0;
                            r_cycleDone <= 1'b1;
                        end
                    end
                    LO_HOLD: begin
                        r_holdCnt <= w_holdInc;
                        if (w_holdInc == HC_LAST) begin
                            r_phase <= UP;
                        end
                    end
                    default: begin
                        r_phase <= UP;
                    end
                endcase
            end
        end
    end

`ifdef LED_BREATHER_GAMMA_EN
    // Squared brightness keeps the upper half of level*level, giving a
    // perceptually even fade; registered to keep the multiplier off the
    // compare path.
    logic [2*PWM_BITS-1:0] w_square;
    logic [PWM_BITS-1:0]   r_duty;

    assign w_square = r_level * r_level;

    always_ff @(posedge sysClk or negedge rstN) begin
        if (!rstN) begin
            r_duty <= '0;
        end else begin
            r_duty <= w_square[2*PWM_BITS-1:PWM_BITS];
        end
    end

    assign w_duty = r_duty;
`else
    assign w_duty = r_level;
`endif

    pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .sysClk (sysClk),
        .rstN   (rstN),
        .en     (en),
        .duty   (w_duty),
        .led    (led)
    );

    assign level     = r_level;
    assign phase     = r_phase;
    assign cycleDone = r_cycleDone;

endmodule

// File: tb/tb_led_breather.sv
// -----------------------------------------------------------------------------
// tb_led_breather
// Self-checking bench for led_breather with CLK_HZ=1000, STEP_HZ=100
// (10 clocks per step), PWM_BITS=4, HOLD_STEPS=2. Full period is 340 clocks.
// Honours LED_BREATHER_GAMMA_EN for the expected PWM duty.
// -----------------------------------------------------------------------------
module tb_led_breather;

    localparam int PWM_BITS = 4;

`ifdef LED_BREATHER_GAMMA_EN
    localparam int HI15 = 14;
`else
    localparam int HI15 = 15;
`endif

    typedef struct {
        int clk;
        int level;
        int phase;
        int cd;
        int ledHi;
    } vec_t;

    logic                sysClk = 1'b0;
    logic                rstN   = 1'b0;
    logic                en     = 1'b0;
    logic                led;
    logic [PWM_BITS-1:0] level;
    logic [1:0]          phase;
    logic                cycleDone;

    int testsRun    = 0;
    int testsFailed = 0;
    int edgeCnt     = 0;
    int cdLog[$];

    // Reference for the PWM pin: free-running counter from reset release,
    // led = en & (count < duty) registered; mDuty is set by the sequences.
    logic [PWM_BITS-1:0] mPwm;
    logic                mLed;
    logic [PWM_BITS-1:0] mDuty = '0;

    led_breather #(
        .CLK_HZ     (1000),
        .STEP_HZ    (100),
        .PWM_BITS   (PWM_BITS),
        .HOLD_STEPS (2)
    ) dut (
        .sysClk    (sysClk),
        .rstN      (rstN),
        .en        (en),
        .led       (led),
        .level     (level),
        .phase     (phase),
        .cycleDone (cycleDone)
    );

    always #5 sysClk = ~sysClk;

    always @(posedge sysClk) edgeCnt <= edgeCnt + 1;

    // Log the edge number of every cycleDone pulse, sampled mid-cycle.
    always @(negedge sysClk) begin
        if (cycleDone === 1'b1) cdLog.push_back(edgeCnt);
    end

    always @(posedge sysClk or negedge rstN) begin
        if (!rstN) begin
            mPwm <= '0;
            mLed <= 1'b0;
        end else begin
            mPwm <= mPwm + 1'b1;
            mLed <= en & (mPwm < mDuty);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) begin
            @(posedge sysClk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic e, input int n);
        en = e;
        clocks(n);
    endtask

    task automatic doReset();
        en   = 1'b0;
        rstN = 1'b0;
        clocks(3);
        rstN = 1'b1;
    endtask

    function automatic logic [PWM_BITS-1:0] expDuty(input int lvl);
`ifdef LED_BREATHER_GAMMA_EN
        return PWM_BITS'((lvl * lvl) >> PWM_BITS);
`else
        return PWM_BITS'(lvl);
`endif
    endfunction

    // Freeze the sequence at a known level by starting each burst with one
    // en-low clock (clears the prescaler) and then nine en-high clocks, which
    // never reaches a tick. Every clock is compared with the PWM reference.
    task automatic holdBurst(input int lvl, input string tag);
        int act;
        int exp;
        mDuty = expDuty(lvl);
        applyStimulus(1'b1, 1);
        for (int b = 0; b < 4; b++) begin
            act = 0;
            exp = 0;
            applyStimulus(1'b0, 1);
            act += int'(led);
            exp += int'(mLed);
            for (int c = 0; c < 9; c++) begin
                applyStimulus(1'b1, 1);
                act += int'(led);
                exp += int'(mLed);
            end
            checkOutput($sformatf("%s_burst%0d_ledHigh", tag, b), act, exp);
        end
        checkOutput({tag, "_levelFrozen"}, int'(level), lvl);
        checkOutput({tag, "_phaseFrozen"}, int'(phase), 0);
    endtask

    initial begin
        vec_t vecs[17];
        int   pos;
        int   hi;
        int   e0;

        vecs[0]  = '{9,   0,  0, 0, -1};
        vecs[1]  = '{10,  1,  0, 0, -1};
        vecs[2]  = '{20,  2,  0, 0, -1};
        vecs[3]  = '{150, 15, 1, 0, -1};
        vecs[4]  = '{153, 15, 1, 0, HI15};
        vecs[5]  = '{170, 15, 2, 0, -1};
        vecs[6]  = '{180, 14, 2, 0, -1};
        vecs[7]  = '{319, 1,  2, 0, -1};
        vecs[8]  = '{320, 0,  3, 1, -1};
        vecs[9]  = '{321, 0,  3, 0, -1};
        vecs[10] = '{323, 0,  3, 0, 0};
        vecs[11] = '{340, 0,  0, 0, -1};
        vecs[12] = '{350, 1,  0, 0, -1};
        vecs[13] = '{659, 1,  2, 0, -1};
        vecs[14] = '{660, 0,  3, 1, -1};
        vecs[15] = '{661, 0,  3, 0, -1};
        vecs[16] = '{710, 3,  0, 0, -1};

        $display("[TB] reset and idle");
        doReset();
        checkOutput("reset_led", int'(led), 0);
        checkOutput("reset_level", int'(level), 0);
        checkOutput("reset_phase", int'(phase), 0);
        checkOutput("reset_cycleDone", int'(cycleDone), 0);

        hi = 0;
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b0, 1);
            hi += int'(led);
        end
        checkOutput("idle_ledHigh", hi, 0);
        checkOutput("idle_level", int'(level), 0);
        checkOutput("idle_phase", int'(phase), 0);
        checkOutput("idle_cycleDoneCount", cdLog.size(), 0);

        $display("[TB] breathing sequence");
        en  = 1'b1;
        e0  = edgeCnt;
        pos = 0;
        foreach (vecs[i]) begin
            clocks(vecs[i].clk - pos);
            pos = vecs[i].clk;
            checkOutput($sformatf("seq@%0d_level", pos), int'(level), vecs[i].level);
            checkOutput($sformatf("seq@%0d_phase", pos), int'(phase), vecs[i].phase);
            checkOutput($sformatf("seq@%0d_cycleDone", pos), int'(cycleDone), vecs[i].cd);
            if (vecs[i].ledHi >= 0) begin
                hi = int'(led);
                for (int c = 0; c < 15; c++) begin
                    clocks(1);
                    hi += int'(led);
                end
                pos += 15;
                checkOutput($sformatf("seq@%0d_ledHighOf16", vecs[i].clk), hi, vecs[i].ledHi);
            end
        end

        checkOutput("cycleDone_count", cdLog.size(), 2);
        if (cdLog.size() >= 2) begin
            checkOutput("cycleDone_first", cdLog[0] - e0, 320);
            checkOutput("cycleDone_second", cdLog[1] - e0, 660);
        end

        $display("[TB] frozen-level PWM");
        holdBurst(3, "lvl3");
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 50);
        checkOutput("resume_level8", int'(level), 8);
        holdBurst(8, "lvl8");
        checkOutput("resume_noCycleDone", cdLog.size(), 2);

        $display("[TB] asynchronous reset in DOWN");
        doReset();
        applyStimulus(1'b1, 200);
        checkOutput("preReset_level", int'(level), 12);
        checkOutput("preReset_phase", int'(phase), 2);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("asyncReset_led", int'(led), 0);
        checkOutput("asyncReset_level", int'(level), 0);
        checkOutput("asyncReset_phase", int'(phase), 0);
        checkOutput("asyncReset_cycleDone", int'(cycleDone), 0);
        clocks(2);
        checkOutput("heldReset_level", int'(level), 0);
        rstN = 1'b1;
        clocks(9);
        checkOutput("release_level@9", int'(level), 0);
        clocks(1);
        checkOutput("release_level@10", int'(level), 1);
        checkOutput("release_phase@10", int'(phase), 0);
        checkOutput("final_cycleDoneCount", cdLog.size(), 2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
